// File: rtl/motor_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module   : motor_pwm_driver
// Purpose  : Turns four 7-bit motor speed commands into PWM drive for a dual
//            H-bridge. Commands are double-buffered at PWM period boundaries
//            and clamped to PWM_STEPS. A direction reversal inserts a coast
//            gap of DEAD_PERIODS whole periods. The two channels of one motor
//            are never driven together.
// Ports    : clk, rst (sync, active-high)
//            speed_a1_a / speed_a1_b : motor A reverse / forward duty command
//            speed_b1_a / speed_b1_b : motor B reverse / forward duty command
//            pwm_a1_a / pwm_a1_b     : motor A reverse / forward pin
//            pwm_b1_a / pwm_b1_b     : motor B reverse / forward pin
//            period_strobe           : 1-cycle pulse on each period boundary
//            fault[1:0]              : sticky conflict flag, bit0 = A, bit1 = B
// Revision : 1.0 - initial release
// ============================================================================
module motor_pwm_driver #(
   parameter int CLK_DIV      = 50,
   parameter int PWM_STEPS    = 100,
   parameter int DEAD_PERIODS = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] speed_a1_a,
   input  logic [6:0] speed_a1_b,
   input  logic [6:0] speed_b1_a,
   input  logic [6:0] speed_b1_b,
   output logic       pwm_a1_a,
   output logic       pwm_a1_b,
   output logic       pwm_b1_a,
   output logic       pwm_b1_b,
   output logic       period_strobe,
   output logic [1:0] fault
);

   localparam int PW  = (CLK_DIV > 1)      ? $clog2(CLK_DIV)          : 1;
   localparam int CW  = (PWM_STEPS > 1)    ? $clog2(PWM_STEPS)        : 1;
   localparam int DCW = (DEAD_PERIODS > 0) ? $clog2(DEAD_PERIODS + 1) : 1;

   localparam logic [PW-1:0]  c_PRE_MAX   = PW'(CLK_DIV - 1);
   localparam logic [CW-1:0]  c_CNT_MAX   = CW'(PWM_STEPS - 1);
   localparam logic [DCW-1:0] c_DEAD_INIT = DCW'(DEAD_PERIODS);
   localparam logic [6:0]     c_DUTY_MAX  = 7'(PWM_STEPS);

   typedef enum logic [1:0] {
      ST_STOP = 2'd0,
      ST_FWD  = 2'd1,
      ST_REV  = 2'd2,
      ST_DEAD = 2'd3
   } state_t;

   // ---------------------------------------------------------------------
   // Shared timebase: prescaler and PWM step counter
   // ---------------------------------------------------------------------
   logic [PW-1:0] r_pre;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_next;
   logic          w_tick;
   logic          w_bnd;

   assign w_tick = (r_pre == c_PRE_MAX);
   assign w_bnd  = w_tick && (r_cnt == c_CNT_MAX);

   always_comb begin
      w_cnt_next = r_cnt;
      if (w_tick) begin
         w_cnt_next = (r_cnt == c_CNT_MAX) ? '0 : r_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pre <= '0;
         r_cnt <= '0;
      end else begin
         r_pre <= w_tick ? '0 : r_pre + 1'b1;
         r_cnt <= w_cnt_next;
      end
   end

   assign period_strobe = w_bnd;

   // ---------------------------------------------------------------------
   // Per-motor channel logic (index 0 = motor A, 1 = motor B)
   // ---------------------------------------------------------------------
   logic [6:0] w_spd_a [2];
   logic [6:0] w_spd_b [2];
   logic [1:0] w_pin_a;
   logic [1:0] w_pin_b;
   logic [1:0] w_fault;

   assign w_spd_a[0] = speed_a1_a;
   assign w_spd_b[0] = speed_a1_b;
   assign w_spd_a[1] = speed_b1_a;
   assign w_spd_b[1] = speed_b1_b;

   genvar m;
   for (m = 0; m < 2; m++) begin : g_motor
      state_t         r_state, w_state_next, w_req_state;
      logic [DCW-1:0] r_dead, w_dead_next;
      logic [6:0]     r_duty_a, r_duty_b, w_duty_a_next, w_duty_b_next;
      logic [6:0]     w_clamp_a, w_clamp_b;
      logic           r_fault, w_fault_next;
      logic           r_pin_a, r_pin_b, w_pin_a_next, w_pin_b_next;
      logic           w_any_a, w_any_b, w_conflict;

      assign w_clamp_a = (32'(w_spd_a[m]) > PWM_STEPS) ? c_DUTY_MAX : w_spd_a[m];
      assign w_clamp_b = (32'(w_spd_b[m]) > PWM_STEPS) ? c_DUTY_MAX : w_spd_b[m];

      assign w_any_a    = |w_spd_a[m];
      assign w_any_b    = |w_spd_b[m];
      assign w_conflict = w_any_a & w_any_b;
      // A conflicting request is treated as STOP.
      assign w_req_state = (w_any_b & ~w_any_a) ? ST_FWD :
                           (w_any_a & ~w_any_b) ? ST_REV : ST_STOP;

      always_comb begin
         w_state_next  = r_state;
         w_dead_next   = r_dead;
         w_duty_a_next = r_duty_a;
         w_duty_b_next = r_duty_b;
         w_fault_next  = r_fault;
         if (w_bnd) begin
            w_duty_a_next = w_clamp_a;
            w_duty_b_next = w_clamp_b;
            if (w_conflict) begin
               w_fault_next = 1'b1;
            end
            case (r_state)
               ST_STOP: w_state_next = w_req_state;
               ST_FWD, ST_REV: begin
                  if ((w_req_state != ST_STOP) && (w_req_state != r_state)
                      && (DEAD_PERIODS > 0)) begin
                     w_state_next = ST_DEAD;
                     w_dead_next  = c_DEAD_INIT;
                  end else begin
                     w_state_next = w_req_state;
                  end
               end
               default: begin
                  // Leaving DEAD follows the request seen on the boundary
                  // where the counter expires.
                  w_dead_next = r_dead - 1'b1;
                  if (r_dead <= DCW'(1)) begin
                     w_dead_next  = '0;
                     w_state_next = w_req_state;
                  end
               end
            endcase
         end
      end

      // Pins are computed from next-cycle count/state/duty so a new period's
      // duty shows up on the very first cycle of that period.
      assign w_pin_a_next = (w_state_next == ST_REV) &&
                            (32'(w_cnt_next) < 32'(w_duty_a_next));
      assign w_pin_b_next = (w_state_next == ST_FWD) &&
                            (32'(w_cnt_next) < 32'(w_duty_b_next));

      always_ff @(posedge clk) begin
         if (rst) begin
            r_state  <= ST_STOP;
            r_dead   <= '0;
            r_duty_a <= '0;
            r_duty_b <= '0;
            r_fault  <= 1'b0;
            r_pin_a  <= 1'b0;
            r_pin_b  <= 1'b0;
         end else begin
            r_state  <= w_state_next;
            r_dead   <= w_dead_next;
            r_duty_a <= w_duty_a_next;
            r_duty_b <= w_duty_b_next;
            r_fault  <= w_fault_next;
            r_pin_a  <= w_pin_a_next;
            r_pin_b  <= w_pin_b_next;
         end
      end

      assign w_pin_a[m] = r_pin_a;
      assign w_pin_b[m] = r_pin_b;
      assign w_fault[m] = r_fault;
   end

   assign pwm_a1_a = w_pin_a[0];
   assign pwm_a1_b = w_pin_b[0];
   assign pwm_b1_a = w_pin_a[1];
   assign pwm_b1_b = w_pin_b[1];
   assign fault    = w_fault;

endmodule
`default_nettype wire

// File: doc/motor_pwm_driver.md
Name: motor_pwm_driver

Overview:
Converts the four 7-bit motor speed commands from the navigation controller into PWM pin drive for the dual H-bridge. Each motor has two channels: `_b` is forward and `_a` is reverse. Motor A uses speed_a1_a/speed_a1_b; motor B uses speed_b1_a/speed_b1_b. The block sits between the controller's speed outputs and the motor driver pins. It double-buffers commands at period boundaries, clamps duty, and enforces coast dead-time on direction reversal and never drives both channels of one motor.

Parameters:
- CLK_DIV, 50: clk cycles per PWM tick (>=1).
- PWM_STEPS, 100: ticks per PWM period; duty unit is 1 tick.
- DEAD_PERIODS, 2: full PWM periods with both channels low on a direction reversal (0 = no dead-time).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- speed_a1_a  in  7  motor A reverse duty command.
- speed_a1_b  in  7  motor A forward duty command.
- speed_b1_a  in  7  motor B reverse duty command.
- speed_b1_b  in  7  motor B forward duty command.
- pwm_a1_a  out  1  motor A reverse pin.
- pwm_a1_b  out  1  motor A forward pin.
- pwm_b1_a  out  1  motor B reverse pin.
- pwm_b1_b  out  1  motor B forward pin.
- period_strobe  out  1  1-cycle pulse at each period boundary.
- fault  out  2  sticky conflict flag; bit0 = motor A, bit1 = motor B.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous, active-high (rst).
- Reset (sync, rst=1 at posedge): prescaler=0, pwm_cnt=0, all shadow duties=0, both motor FSMs=STOP, dead counters=0. All pwm_* = 0, period_strobe=0, fault=0.
- Reset mid-period: pins low from the next cycle; the period restarts from pwm_cnt=0.
- Prescaler: counts 0..CLK_DIV-1. tick=1 on the cycle it equals CLK_DIV-1, then it wraps to 0.
- pwm_cnt: advances on tick over 0..PWM_STEPS-1 and wraps.
- Boundary: tick && pwm_cnt==PWM_STEPS-1. period_strobe is asserted exactly that cycle.
- First boundary after reset occurs on cycle CLK_DIV*PWM_STEPS-1.
- Load at boundary edge: all four inputs are sampled together. Each is clamped: value > PWM_STEPS becomes PWM_STEPS. Between boundaries, input changes are ignored.
- Pin equation: pin = (state permits channel) && (pwm_cnt < shadow_duty), registered.
  - The new period's duty is visible from the first cycle with pwm_cnt=0, i.e. latency of 1 clk from the boundary edge.
  - duty 0 gives a constant-low pin; duty PWM_STEPS gives a constant-high pin.
- Request decode per motor at load:
  - both 0 → STOP.
  - _b>0, _a=0 → FWD.
  - _a>0, _b=0 → REV.
  - both >0 → CONFLICT: fault bit set (sticky until rst); treated as STOP.
- Per-motor FSM states: STOP, FWD, REV, DEAD. Transitions are evaluated only at boundaries:
  - STOP → FWD/REV immediately; no dead-time.
  - FWD/REV → same direction: stay; new duty applies.
  - FWD/REV → STOP: STOP.
  - FWD↔REV (reversal): DEAD with dead_cnt=DEAD_PERIODS. If DEAD_PERIODS=0, go directly to the new direction.
  - DEAD: both pins low.
    - At each boundary, dead_cnt decrements and the shadow reloads.
    - When dead_cnt reaches 0, the state becomes the decode of that boundary's request (FWD/REV/STOP).
    - A CONFLICT during DEAD sets fault; the motor continues counting dead-time and then goes to STOP.
- Invariant: pwm_x_a and pwm_x_b are never both 1 for the same motor, in any cycle.
- Motors A and B are independent; simultaneous reversals on both are handled in parallel.

Test Plan:
- Basic duty: rst, then speed_a1_b=60, others 0 → after the first period_strobe, pwm_a1_b is high for 60*CLK_DIV cycles of every 100*CLK_DIV; pwm_a1_a stays 0.
- Clamp and extremes: speed_b1_b=127 → pwm_b1_b constantly high for the full period. speed_b1_b=0 → constantly low.
- Double-buffering: speed_a1_b 60→30 changed at pwm_cnt=10 → the current period still gives 60 ticks high; the next period gives 30.
- Reversal: a1_b=50 running, then a1_a=50, a1_b=0 → both motor A pins low for exactly 2 full periods, then pwm_a1_a has 50-tick duty. Motor B is unaffected.
- Conflict: speed_a1_a=20, speed_a1_b=20 → both motor A pins low, fault=2'b01. Inputs then corrected → fault stays 1 until rst.
- Reset mid-period: assert rst at pwm_cnt=40 with duty 80 → all pins 0 the next cycle; period_strobe next fires CLK_DIV*PWM_STEPS cycles after rst deasserts.
